// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier with valid/ready handshakes on both sides.
// Optional early termination on an exhausted multiplier: define MULT_EARLY_TERM_EN.
module seq_shift_add_multiplier #(
  parameter int A_WIDTH = 4,
  parameter int B_WIDTH = 3,
  parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] p,
  output logic               busy
);
  localparam int CW = $clog2(B_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(B_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [P_WIDTH-1:0] acc;
  logic [P_WIDTH-1:0] mcand;
  logic [B_WIDTH-1:0] mplier;
  logic [CW-1:0]      cnt;
  logic               last_step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          acc    <= '0;
          mcand  <= {{(P_WIDTH-A_WIDTH){1'b0}}, a};
          mplier <= b;
          cnt    <= '0;
        end
        RUN: begin
          acc    <= acc + (mplier[0] ? mcand : '0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Final step when the count runs out, or when no multiplier bits remain above bit 0.
`ifdef MULT_EARLY_TERM_EN
  assign last_step = (cnt == CNT_LAST) || (mplier[B_WIDTH-1:1] == '0);
`else
  assign last_step = (cnt == CNT_LAST);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign p         = acc;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier: default 4x3 instance plus an 8x8 instance.
module tb_seq_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  a = '0;
  logic [2:0]  b = '0;
  logic        in_ready, out_valid, busy;
  logic [6:0]  p;
  logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, busy8;
  logic [15:0] p8;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy));

  seq_shift_add_multiplier #(.A_WIDTH(8), .B_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .p(p8), .busy(busy8));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int lat4(input int bv);
`ifdef MULT_EARLY_TERM_EN
    int l = 1;
    for (int i = 0; i < 3; i++) if (bv[i]) l = i + 1;
    return l;
`else
    return 3;
`endif
  endfunction

  // One transaction on the 4x3 instance; hold>0 applies backpressure for that many cycles.
  task automatic mult4(input int av, input int bv, input int exp_p, input int exp_lat, input int hold);
    int lat = 0, busy_n = 0, rdy_n = 0;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    a = av[3:0]; b = bv[2:0]; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_n++;
      if (in_ready) rdy_n++;
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("latency", lat, exp_lat);
    chk("busy_cycles", busy_n, exp_lat);
    chk("in_ready_run", rdy_n, 0);
    chk("p", p, exp_p);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 4'd3;
      @(negedge clk);
      chk("bp_p", p, exp_p);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
  endtask

  task automatic mult8(input int av, input int bv, input int exp_p, input int exp_lat);
    int lat = 0;
    @(negedge clk);
    a8 = av[7:0]; b8 = bv[7:0]; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("lat8", lat, exp_lat);
    chk("p8", p8, exp_p);
    @(posedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p", p, 0);
    rst_n = 1'b1;

    mult4(15, 7, 105, lat4(7), 0);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 8; j++)
        mult4(i, j, i * j, lat4(j), 0);

    mult4(9, 5, 45, lat4(5), 10);
    mult4(3, 5, 15, lat4(5), 0);

    // Reset asserted for the second RUN edge of an in-flight 12x6.
    @(negedge clk);
    a = 4'd12; b = 3'd6; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_p", p, 0);
    rst_n = 1'b1;
    mult4(2, 3, 6, lat4(3), 0);

`ifdef MULT_EARLY_TERM_EN
    mult4(7, 0, 0, 1, 0);
    mult4(13, 1, 13, 1, 0);
    mult4(10, 4, 40, 3, 0);
    mult4(5, 3, 15, 2, 0);
`endif

    mult8(255, 255, 65025, 8);
    mult8(0, 200, 0, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
